// File: rtl/regfile_wr_ctrl_if.sv
// Register-file write port bundle.
// Carries the three write requesters (ALU byte, data-bus byte, IDU pair),
// their grant pulses, and the load-strobe / write-data / busy outputs that
// feed the regbit arrays.
//   slave  : the write controller (samples requests, drives grants and strobes)
//   master : the requesters / register file side
interface regfile_wr_ctrl_if;
   logic        alu_req;
   logic [2:0]  alu_sel;
   logic [7:0]  alu_d;
   logic        dbus_req;
   logic [2:0]  dbus_sel;
   logic [7:0]  dbus_d;
   logic        idu_req;
   logic [1:0]  idu_pair;
   logic [15:0] idu_d;
   logic        alu_gnt;
   logic        dbus_gnt;
   logic        idu_gnt;
   logic [7:0]  ld;
   logic [15:0] wd;
   logic        busy;

   modport slave (
      input  alu_req, alu_sel, alu_d,
      input  dbus_req, dbus_sel, dbus_d,
      input  idu_req, idu_pair, idu_d,
      output alu_gnt, dbus_gnt, idu_gnt,
      output ld, wd, busy
   );

   modport master (
      output alu_req, alu_sel, alu_d,
      output dbus_req, dbus_sel, dbus_d,
      output idu_req, idu_pair, idu_d,
      input  alu_gnt, dbus_gnt, idu_gnt,
      input  ld, wd, busy
   );
endinterface

// File: rtl/regfile_wr_ctrl.sv
// Register-file write controller.
// Arbitrates ALU byte writes, data-bus byte writes and IDU pair writes into
// the 8-register file (ld index 0..7 = B,C,D,E,H,L,F,A). Each accepted write
// takes a LOAD cycle (strobes high) followed by a HOLD cycle (strobes low,
// data held) so wd is stable across the ld falling edge where regbit captures.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : regfile_wr_ctrl_if.slave (requests in; grants, ld, wd, busy out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no write in progress; any request starts a LOAD
// LOAD  | one cycle: ld strobes and winner's gnt high, wd valid
// HOLD  | one cycle: ld low, wd held; new request chains into LOAD
module regfile_wr_ctrl (
   input  logic                    clk,
   input  logic                    reset,
   regfile_wr_ctrl_if.slave        bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_nxt;
   logic [7:0]  ld_q, ld_nxt;
   logic [15:0] wd_q, wd_nxt;
   logic        alu_gnt_q, alu_gnt_nxt;
   logic        dbus_gnt_q, dbus_gnt_nxt;
   logic        idu_gnt_q, idu_gnt_nxt;
   logic [1:0]  starv_q, starv_nxt;
   logic        rr_dbus_next_q, rr_dbus_next_nxt;

   logic        byte_pend;
   logic        any_req;
   logic        idu_win;
   logic        alu_win;

   assign byte_pend = bus.alu_req | bus.dbus_req;
   assign any_req   = byte_pend | bus.idu_req;
   // IDU has priority unless it has already won twice in a row over a
   // waiting byte requester.
   assign idu_win   = bus.idu_req & ~(byte_pend & (starv_q == 2'd2));
   assign alu_win   = ~idu_win & bus.alu_req & (~bus.dbus_req | ~rr_dbus_next_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         ld_q           <= '0;
         wd_q           <= '0;
         alu_gnt_q      <= 1'b0;
         dbus_gnt_q     <= 1'b0;
         idu_gnt_q      <= 1'b0;
         starv_q        <= '0;
         rr_dbus_next_q <= 1'b0;
      end else begin
         state_q        <= state_nxt;
         ld_q           <= ld_nxt;
         wd_q           <= wd_nxt;
         alu_gnt_q      <= alu_gnt_nxt;
         dbus_gnt_q     <= dbus_gnt_nxt;
         idu_gnt_q      <= idu_gnt_nxt;
         starv_q        <= starv_nxt;
         rr_dbus_next_q <= rr_dbus_next_nxt;
      end
   end

   always_comb begin
      state_nxt        = state_q;
      ld_nxt           = '0;
      wd_nxt           = wd_q;
      alu_gnt_nxt      = 1'b0;
      dbus_gnt_nxt     = 1'b0;
      idu_gnt_nxt      = 1'b0;
      starv_nxt        = starv_q;
      rr_dbus_next_nxt = rr_dbus_next_q;

      case (state_q)
         IDLE, HOLD: begin
            if (any_req) begin
               state_nxt = LOAD;
               if (idu_win) begin
                  idu_gnt_nxt = 1'b1;
                  ld_nxt      = 8'd3 << {bus.idu_pair, 1'b0};
                  wd_nxt      = bus.idu_d;
                  starv_nxt   = byte_pend ? starv_q + 2'd1 : 2'd0;
               end else if (alu_win) begin
                  alu_gnt_nxt      = 1'b1;
                  ld_nxt           = 8'd1 << bus.alu_sel;
                  wd_nxt           = {bus.alu_d, bus.alu_d};
                  starv_nxt        = 2'd0;
                  rr_dbus_next_nxt = 1'b1;
               end else begin
                  dbus_gnt_nxt     = 1'b1;
                  ld_nxt           = 8'd1 << bus.dbus_sel;
                  wd_nxt           = {bus.dbus_d, bus.dbus_d};
                  starv_nxt        = 2'd0;
                  rr_dbus_next_nxt = 1'b0;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            state_nxt = HOLD;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.ld       = ld_q;
   assign bus.wd       = wd_q;
   assign bus.alu_gnt  = alu_gnt_q;
   assign bus.dbus_gnt = dbus_gnt_q;
   assign bus.idu_gnt  = idu_gnt_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed testbench for regfile_wr_ctrl with hand-computed expectations.
module tb_regfile_wr_ctrl;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   regfile_wr_ctrl_if bus_if ();

   regfile_wr_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   function automatic logic [2:0] gnts();
      return {bus_if.idu_gnt, bus_if.alu_gnt, bus_if.dbus_gnt};
   endfunction

   task automatic drop_reqs();
      bus_if.alu_req  = 1'b0;
      bus_if.dbus_req = 1'b0;
      bus_if.idu_req  = 1'b0;
   endtask

   logic [2:0]  rr_gnt  [4] = '{3'b010, 3'b001, 3'b010, 3'b001};
   logic [7:0]  rr_ld   [4] = '{8'h01, 8'h80, 8'h01, 8'h80};
   logic [15:0] rr_wd   [4] = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
   logic [2:0]  st_gnt  [6] = '{3'b100, 3'b100, 3'b010, 3'b100, 3'b100, 3'b001};
   logic [7:0]  st_ld   [6] = '{8'h03, 8'h03, 8'h01, 8'h03, 8'h03, 8'h80};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      drop_reqs();
      bus_if.alu_sel  = 3'd0;
      bus_if.alu_d    = 8'h00;
      bus_if.dbus_sel = 3'd0;
      bus_if.dbus_d   = 8'h00;
      bus_if.idu_pair = 2'd0;
      bus_if.idu_d    = 16'h0000;

      // reset state
      tick();
      chk("rst_ld", {8'h00, bus_if.ld}, 16'h0000);
      chk("rst_wd", bus_if.wd, 16'h0000);
      chk("rst_busy", {15'd0, bus_if.busy}, 16'h0000);
      chk("rst_gnt", {13'd0, gnts()}, 16'h0000);
      reset = 1'b0;
      tick();

      // single byte write
      bus_if.alu_req = 1'b1;
      bus_if.alu_sel = 3'd2;
      bus_if.alu_d   = 8'h5A;
      tick();
      chk("byte_load_ld", {8'h00, bus_if.ld}, 16'h0004);
      chk("byte_load_wd", bus_if.wd, 16'h5A5A);
      chk("byte_load_gnt", {13'd0, gnts()}, 16'h0002);
      chk("byte_load_busy", {15'd0, bus_if.busy}, 16'h0001);
      drop_reqs();
      tick();
      chk("byte_hold_ld", {8'h00, bus_if.ld}, 16'h0000);
      chk("byte_hold_wd", bus_if.wd, 16'h5A5A);
      chk("byte_hold_gnt", {13'd0, gnts()}, 16'h0000);
      tick();
      chk("byte_idle_busy", {15'd0, bus_if.busy}, 16'h0000);

      // pair write
      bus_if.idu_req  = 1'b1;
      bus_if.idu_pair = 2'd2;
      bus_if.idu_d    = 16'hC0DE;
      tick();
      chk("pair_load_ld", {8'h00, bus_if.ld}, 16'h0030);
      chk("pair_load_wd", bus_if.wd, 16'hC0DE);
      chk("pair_load_gnt", {13'd0, gnts()}, 16'h0004);
      drop_reqs();
      tick();
      chk("pair_hold_ld", {8'h00, bus_if.ld}, 16'h0000);
      chk("pair_hold_wd", bus_if.wd, 16'hC0DE);
      tick();
      chk("pair_idle_busy", {15'd0, bus_if.busy}, 16'h0000);

      // round-robin alu/dbus
      do_reset();
      bus_if.alu_sel  = 3'd0;
      bus_if.alu_d    = 8'h11;
      bus_if.dbus_sel = 3'd7;
      bus_if.dbus_d   = 8'h22;
      bus_if.alu_req  = 1'b1;
      bus_if.dbus_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("rr_gnt%0d", i), {13'd0, gnts()}, {13'd0, rr_gnt[i]});
         chk($sformatf("rr_ld%0d", i), {8'h00, bus_if.ld}, {8'h00, rr_ld[i]});
         chk($sformatf("rr_wd%0d", i), bus_if.wd, rr_wd[i]);
         if (i == 3) drop_reqs();
         tick();
         chk($sformatf("rr_hold_ld%0d", i), {8'h00, bus_if.ld}, 16'h0000);
         chk($sformatf("rr_hold_gnt%0d", i), {13'd0, gnts()}, 16'h0000);
      end
      tick();
      chk("rr_idle_busy", {15'd0, bus_if.busy}, 16'h0000);

      // starvation guard
      do_reset();
      bus_if.idu_pair = 2'd0;
      bus_if.idu_d    = 16'hBEEF;
      bus_if.idu_req  = 1'b1;
      bus_if.alu_req  = 1'b1;
      bus_if.dbus_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("starv_gnt%0d", i), {13'd0, gnts()}, {13'd0, st_gnt[i]});
         chk($sformatf("starv_ld%0d", i), {8'h00, bus_if.ld}, {8'h00, st_ld[i]});
         if (i == 5) drop_reqs();
         tick();
         chk($sformatf("starv_hold_ld%0d", i), {8'h00, bus_if.ld}, 16'h0000);
      end
      tick();
      chk("starv_idle_busy", {15'd0, bus_if.busy}, 16'h0000);

      // reset in the middle of LOAD
      do_reset();
      bus_if.alu_req = 1'b1;
      bus_if.alu_sel = 3'd0;
      bus_if.alu_d   = 8'hA5;
      tick();
      chk("midrst_pre_ld", {8'h00, bus_if.ld}, 16'h0001);
      drop_reqs();
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_ld", {8'h00, bus_if.ld}, 16'h0000);
      chk("midrst_wd", bus_if.wd, 16'h0000);
      chk("midrst_busy", {15'd0, bus_if.busy}, 16'h0000);
      chk("midrst_gnt", {13'd0, gnts()}, 16'h0000);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("midrst_after_busy%0d", i), {15'd0, bus_if.busy}, 16'h0000);
         chk($sformatf("midrst_after_ld%0d", i), {8'h00, bus_if.ld}, 16'h0000);
      end

      // idle with no requests
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("idle_ld%0d", i), {8'h00, bus_if.ld}, 16'h0000);
         chk($sformatf("idle_gnt%0d", i), {13'd0, gnts()}, 16'h0000);
         chk($sformatf("idle_busy%0d", i), {15'd0, bus_if.busy}, 16'h0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
